// File: rtl/execute_div_result.sv
// Result stage for DIV/IDIV/AAM: waits on the divider, holds the formatted
// EAX/EDX/flags result for writeback, or raises #DE on a divider exception.

`ifndef CMD_DIV
`define CMD_DIV  7'd49
`endif
`ifndef CMD_IDIV
`define CMD_IDIV 7'd50
`endif
`ifndef CMD_AAM
`define CMD_AAM  7'd51
`endif

module execute_div_result #(
    parameter logic [7:0] DE_VECTOR = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_reset,
    input  logic        exe_start,
    input  logic [6:0]  exe_cmd,
    input  logic        exe_is_8bit,
    input  logic        exe_operand_16bit,
    input  logic        exe_operand_32bit,
    input  logic [31:0] eax,
    input  logic [31:0] edx,
    input  logic        div_busy,
    input  logic        exe_div_exception,
    input  logic [31:0] div_result_quotient,
    input  logic [31:0] div_result_remainder,
    input  logic        wr_ready,
    input  logic        exc_ack,
    output logic        busy,
    output logic        exe_ready,
    output logic        wr_valid,
    output logic [31:0] wr_eax,
    output logic [31:0] wr_edx,
    output logic        wr_edx_en,
    output logic        wr_flags_en,
    output logic        wr_sf,
    output logic        wr_zf,
    output logic        wr_pf,
    output logic        exc_valid,
    output logic [7:0]  exc_vector,
    output logic [1:0]  state_dbg
);

    // Writeback handshake: wr_valid holds the result stable until a cycle with
    // wr_valid & wr_ready; that cycle is the transfer and exe_ready pulses in it.
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, EXC} state_t;

    state_t state, state_nxt;

    logic        is_aam_q, is_8bit_q, is_32bit_q;
    logic [15:0] eax_hi_q, edx_hi_q;
    logic [31:0] res_eax_q, res_edx_q;
    logic        res_edx_en_q, res_flags_en_q, res_sf_q, res_zf_q, res_pf_q;

    logic [31:0] fmt_eax, fmt_edx;
    logic        fmt_edx_en, fmt_flags_en, fmt_sf, fmt_zf, fmt_pf;
    logic [7:0]  al;
    logic        start_accept, capture;

    // Only the upper halves of EAX/EDX survive into the merged result.
    logic unused_low_halves;
    assign unused_low_halves = ^{eax[15:0], edx[15:0]};

    assign start_accept = (state == IDLE) && exe_start && !exe_reset;
    assign capture      = (state == WAIT) && !exe_div_exception && !div_busy && !exe_reset;

    always_comb begin
        al           = div_result_remainder[7:0];
        fmt_eax      = 32'd0;
        fmt_edx      = 32'd0;
        fmt_edx_en   = 1'b0;
        fmt_flags_en = 1'b0;
        fmt_sf       = 1'b0;
        fmt_zf       = 1'b0;
        fmt_pf       = 1'b0;
        if (is_aam_q) begin
            fmt_eax      = {eax_hi_q, div_result_quotient[7:0], al};
            fmt_flags_en = 1'b1;
            fmt_sf       = al[7];
            fmt_zf       = (al == 8'd0);
            fmt_pf       = ~^al;
        end else if (is_8bit_q) begin
            fmt_eax = {eax_hi_q, al, div_result_quotient[7:0]};
        end else if (is_32bit_q) begin
            fmt_eax    = div_result_quotient;
            fmt_edx    = div_result_remainder;
            fmt_edx_en = 1'b1;
        end else begin
            fmt_eax    = {eax_hi_q, div_result_quotient[15:0]};
            fmt_edx    = {edx_hi_q, div_result_remainder[15:0]};
            fmt_edx_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Exception is tested before busy so a late overflow never reaches HOLD.
    always_comb begin
        state_nxt = state;
        if (exe_reset) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (exe_start) state_nxt = WAIT;
                WAIT: begin
                    if (exe_div_exception) state_nxt = EXC;
                    else if (!div_busy)    state_nxt = HOLD;
                end
                HOLD: if (wr_ready)  state_nxt = IDLE;
                EXC:  if (exc_ack)   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_aam_q       <= 1'b0;
            is_8bit_q      <= 1'b0;
            is_32bit_q     <= 1'b0;
            eax_hi_q       <= 16'd0;
            edx_hi_q       <= 16'd0;
            res_eax_q      <= 32'd0;
            res_edx_q      <= 32'd0;
            res_edx_en_q   <= 1'b0;
            res_flags_en_q <= 1'b0;
            res_sf_q       <= 1'b0;
            res_zf_q       <= 1'b0;
            res_pf_q       <= 1'b0;
        end else begin
            if (start_accept) begin
                is_aam_q   <= (exe_cmd == `CMD_AAM);
                is_8bit_q  <= exe_is_8bit;
                is_32bit_q <= exe_operand_32bit && !exe_operand_16bit;
                eax_hi_q   <= eax[31:16];
                edx_hi_q   <= edx[31:16];
            end
            if (capture) begin
                res_eax_q      <= fmt_eax;
                res_edx_q      <= fmt_edx;
                res_edx_en_q   <= fmt_edx_en;
                res_flags_en_q <= fmt_flags_en;
                res_sf_q       <= fmt_sf;
                res_zf_q       <= fmt_zf;
                res_pf_q       <= fmt_pf;
            end
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        wr_valid    = (state == HOLD);
        exe_ready   = (state == HOLD) && wr_ready && !exe_reset;
        wr_eax      = wr_valid ? res_eax_q      : 32'd0;
        wr_edx      = wr_valid ? res_edx_q      : 32'd0;
        wr_edx_en   = wr_valid && res_edx_en_q;
        wr_flags_en = wr_valid && res_flags_en_q;
        wr_sf       = wr_valid && res_sf_q;
        wr_zf       = wr_valid && res_zf_q;
        wr_pf       = wr_valid && res_pf_q;
        exc_valid   = (state == EXC);
        exc_vector  = exc_valid ? DE_VECTOR : 8'd0;
        state_dbg   = state;
    end

endmodule

// File: tb/tb_execute_div_result.sv
// Bench for execute_div_result: directed cases plus randomized transactions
// checked against an arithmetic model of the result-merging rules.

`ifndef CMD_DIV
`define CMD_DIV  7'd49
`endif
`ifndef CMD_IDIV
`define CMD_IDIV 7'd50
`endif
`ifndef CMD_AAM
`define CMD_AAM  7'd51
`endif

module tb_execute_div_result;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_reset, exe_start;
  logic [6:0]  exe_cmd;
  logic        exe_is_8bit, exe_operand_16bit, exe_operand_32bit;
  logic [31:0] eax, edx;
  logic        div_busy, exe_div_exception;
  logic [31:0] div_result_quotient, div_result_remainder;
  logic        wr_ready, exc_ack;
  logic        busy, exe_ready, wr_valid;
  logic [31:0] wr_eax, wr_edx;
  logic        wr_edx_en, wr_flags_en, wr_sf, wr_zf, wr_pf;
  logic        exc_valid;
  logic [7:0]  exc_vector;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  execute_div_result dut (
    .clk(clk), .rst_n(rst_n), .exe_reset(exe_reset), .exe_start(exe_start),
    .exe_cmd(exe_cmd), .exe_is_8bit(exe_is_8bit),
    .exe_operand_16bit(exe_operand_16bit), .exe_operand_32bit(exe_operand_32bit),
    .eax(eax), .edx(edx), .div_busy(div_busy), .exe_div_exception(exe_div_exception),
    .div_result_quotient(div_result_quotient), .div_result_remainder(div_result_remainder),
    .wr_ready(wr_ready), .exc_ack(exc_ack), .busy(busy), .exe_ready(exe_ready),
    .wr_valid(wr_valid), .wr_eax(wr_eax), .wr_edx(wr_edx), .wr_edx_en(wr_edx_en),
    .wr_flags_en(wr_flags_en), .wr_sf(wr_sf), .wr_zf(wr_zf), .wr_pf(wr_pf),
    .exc_valid(exc_valid), .exc_vector(exc_vector), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 DIV, 1 IDIV, 2 AAM; size: 0 byte, 1 word, 2 dword.
  // xf packs {pf, zf, sf, flags_en, edx_en}.
  function automatic void model(input int kind, input int size,
                                input logic [31:0] e, input logic [31:0] d,
                                input logic [31:0] q, input logic [31:0] r,
                                output logic [31:0] xe, output logic [31:0] xd,
                                output logic [31:0] xf);
    logic [31:0] e_hi, d_hi, al;
    e_hi = (e / 32'd65536) * 32'd65536;
    d_hi = (d / 32'd65536) * 32'd65536;
    al   = r % 32'd256;
    xd = 32'd0;
    xf = 32'd0;
    if (kind == 2) begin
      xe = e_hi + (q % 32'd256) * 32'd256 + al;
      xf = 32'd2;
      if (al >= 32'd128) xf += 32'd4;
      if (al == 32'd0) xf += 32'd8;
      if ($countones(al) % 2 == 0) xf += 32'd16;
    end else if (size == 0) begin
      xe = e_hi + al * 32'd256 + (q % 32'd256);
    end else if (size == 1) begin
      xe = e_hi + (q % 32'd65536);
      xd = d_hi + (r % 32'd65536);
      xf = 32'd1;
    end else begin
      xe = q;
      xd = r;
      xf = 32'd1;
    end
  endfunction

  task automatic drive_start(input int kind, input int size,
                             input logic [31:0] e, input logic [31:0] d);
    exe_start = 1'b1;
    exe_cmd = (kind == 2) ? `CMD_AAM : (kind == 1) ? `CMD_IDIV : `CMD_DIV;
    exe_is_8bit       = (kind == 2) || (size == 0);
    exe_operand_16bit = (kind != 2) && (size == 1);
    exe_operand_32bit = (kind != 2) && (size == 2);
    eax = e;
    edx = d;
    div_busy = 1'b1;
  endtask

  // exc: 0 none, 1 exception while busy, 2 exception with busy low (overflow)
  task automatic run_txn(input int kind, input int size,
                         input logic [31:0] e, input logic [31:0] d,
                         input logic [31:0] q, input logic [31:0] r,
                         input int nb, input int exc, input int nhold, input bit poke);
    logic [31:0] xe, xd, xf, pe, pd, pf;
    model(kind, size, e, d, q, r, xe, xd, xf);
    exp_q.push_back(xe);
    exp_q.push_back(xd);
    exp_q.push_back(xf);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    drive_start(kind, size, e, d);
    tick();
    exe_start = 1'b0;
    eax = $urandom;
    edx = $urandom;
    for (int i = 0; i < nb; i++) begin
      div_busy = 1'b1;
      div_result_quotient = $urandom;
      div_result_remainder = $urandom;
      #1;
      check("wait_busy", {31'd0, busy}, 32'd1);
      check("wait_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("wait_exc_valid", {31'd0, exc_valid}, 32'd0);
      tick();
    end
    div_busy = (exc == 1);
    exe_div_exception = (exc != 0);
    div_result_quotient = q;
    div_result_remainder = r;
    tick();
    exe_div_exception = 1'b0;
    div_busy = 1'b0;
    div_result_quotient = $urandom;
    div_result_remainder = $urandom;
    pe = exp_q.pop_front();
    pd = exp_q.pop_front();
    pf = exp_q.pop_front();
    if (exc != 0) begin
      for (int i = 0; i < nhold; i++) begin
        wr_ready = 1'($urandom_range(0, 1));
        #1;
        check("exc_valid", {31'd0, exc_valid}, 32'd1);
        check("exc_vector", {24'd0, exc_vector}, 32'd0);
        check("exc_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("exc_exe_ready", {31'd0, exe_ready}, 32'd0);
        tick();
      end
      wr_ready = 1'b0;
      exc_ack = 1'b1;
      #1;
      check("exc_ack_valid", {31'd0, exc_valid}, 32'd1);
      check("exc_ack_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("exc_ack_exe_ready", {31'd0, exe_ready}, 32'd0);
      tick();
      exc_ack = 1'b0;
      #1;
      check("exc_done_valid", {31'd0, exc_valid}, 32'd0);
      check("exc_done_busy", {31'd0, busy}, 32'd0);
      check("exc_done_exe_ready", {31'd0, exe_ready}, 32'd0);
    end else begin
      for (int i = 0; i < nhold; i++) begin
        wr_ready = 1'b0;
        exc_ack = 1'($urandom_range(0, 1));
        if (poke && i == 0) drive_start($urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom);
        div_busy = 1'b0;
        #1;
        check("hold_wr_valid", {31'd0, wr_valid}, 32'd1);
        check("hold_eax", wr_eax, pe);
        check("hold_edx", wr_edx, pd);
        check("hold_flags", {27'd0, wr_pf, wr_zf, wr_sf, wr_flags_en, wr_edx_en}, pf);
        check("hold_exe_ready", {31'd0, exe_ready}, 32'd0);
        check("hold_exc_valid", {31'd0, exc_valid}, 32'd0);
        tick();
        exe_start = 1'b0;
        exc_ack = 1'b0;
      end
      wr_ready = 1'b1;
      #1;
      check("accept_exe_ready", {31'd0, exe_ready}, 32'd1);
      check("accept_eax", wr_eax, pe);
      check("accept_edx", wr_edx, pd);
      check("accept_flags", {27'd0, wr_pf, wr_zf, wr_sf, wr_flags_en, wr_edx_en}, pf);
      tick();
      wr_ready = 1'b0;
      #1;
      check("post_exe_ready", {31'd0, exe_ready}, 32'd0);
      check("post_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("post_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    exe_reset = 1'b0; exe_start = 1'b0; exe_cmd = 7'd0;
    exe_is_8bit = 1'b0; exe_operand_16bit = 1'b0; exe_operand_32bit = 1'b0;
    eax = 32'd0; edx = 32'd0; div_busy = 1'b0; exe_div_exception = 1'b0;
    div_result_quotient = 32'd0; div_result_remainder = 32'd0;
    wr_ready = 1'b0; exc_ack = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_eax", wr_eax, 32'd0);
    check("rst_edx", wr_edx, 32'd0);
    check("rst_flags", {27'd0, wr_pf, wr_zf, wr_sf, wr_flags_en, wr_edx_en}, 32'd0);
    check("rst_exc", {23'd0, exc_valid, exc_vector}, 32'd0);
    check("rst_exe_ready", {31'd0, exe_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // DIV 8-bit 100/7, writeback stalls three cycles
    run_txn(0, 0, 32'h1234_0064, 32'h0, 32'h0000_000E, 32'h0000_0002, 3, 0, 3, 0);
    // IDIV 16-bit -7/2
    run_txn(1, 1, 32'h5555_FFF9, 32'hAAAA_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 0, 1, 0);
    // DIV 32-bit by zero, exception in first WAIT cycle
    run_txn(0, 2, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 0, 1, 2, 0);
    // overflow: exception and busy low together
    run_txn(1, 2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 4, 2, 1, 0);
    // AAM 0x63 and 0x0A
    run_txn(2, 0, 32'hDEAD_0063, 32'h0, 32'h9, 32'h9, 1, 0, 1, 0);
    run_txn(2, 0, 32'hBEEF_000A, 32'h0, 32'h1, 32'h0, 1, 0, 0, 0);
    // exe_start pulsed while holding a result
    run_txn(0, 2, 32'h0, 32'h0, 32'h0123_4567, 32'h89AB_CDEF, 1, 0, 2, 1);

    // flush while waiting on the divider
    drive_start(0, 2, $urandom, $urandom);
    tick();
    exe_start = 1'b0;
    exe_reset = 1'b1;
    div_busy = 1'b1;
    tick();
    exe_reset = 1'b0;
    div_busy = 1'b0;
    #1;
    check("flush_wait_busy", {31'd0, busy}, 32'd0);
    check("flush_wait_wr_valid", {31'd0, wr_valid}, 32'd0);
    tick();

    // flush while holding, with wr_ready in the same cycle
    drive_start(1, 1, $urandom, $urandom);
    tick();
    exe_start = 1'b0;
    div_busy = 1'b0;
    div_result_quotient = $urandom;
    div_result_remainder = $urandom;
    tick();
    #1;
    check("flush_hold_valid", {31'd0, wr_valid}, 32'd1);
    exe_reset = 1'b1;
    wr_ready = 1'b1;
    #1;
    check("flush_hold_exe_ready", {31'd0, exe_ready}, 32'd0);
    tick();
    exe_reset = 1'b0;
    wr_ready = 1'b0;
    #1;
    check("flush_hold_busy", {31'd0, busy}, 32'd0);
    check("flush_hold_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("flush_hold_exe_ready2", {31'd0, exe_ready}, 32'd0);
    tick();

    // randomized transactions
    for (int n = 0; n < 60; n++) begin
      int kind, size, sel, exc, nhold;
      kind  = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      sel   = $urandom_range(0, 5);
      exc   = (sel == 4) ? 1 : (sel == 5) ? 2 : 0;
      nhold = $urandom_range(0, 3);
      run_txn(kind, size, $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 5), exc, nhold, (nhold > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
